addr_mux_pipe: RTL and testbench
================================

ADDR_MUX_PIPE -- requirements
Module: addr_mux_pipe

Interface
REQ-001 Parameter WIDTH, default 5: bit width of each address channel.
REQ-002 Parameter NUM_IN, default 2: number of input channels (2..16).
REQ-003 Localparam SEL_W = max(1, clog2(NUM_IN)): select width; derived, not overridable.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 addr_in  input  NUM_IN*WIDTH  flattened channels; channel k at bits [k*WIDTH +: WIDTH].
REQ-007 sel  input  SEL_W  channel select, sampled with the input handshake.
REQ-008 in_valid  input  1  upstream presents addr_in/sel.
REQ-009 in_ready  output  1  block can accept a word; registered, no combinational path from out_ready.
REQ-010 addr_out  output  WIDTH  selected address, registered.
REQ-011 out_valid  output  1  addr_out holds a valid word.
REQ-012 out_ready  input  1  downstream consumes addr_out.
REQ-013 sel_err  output  1  present only with ADDR_MUX_PIPE_SELCHK_EN; flags the word on addr_out as out-of-range select.

Function
REQ-014 Input transfer occurs on a cycle with in_valid && in_ready; output transfer on out_valid && out_ready.
REQ-015 Captured word = channel sel of addr_in at the transfer cycle; word reaches addr_out with out_valid high the next cycle (latency 1).
REQ-016 sel >= NUM_IN (non-power-of-two NUM_IN) captures all-zero word; the transfer still completes.
REQ-017 Storage: main register (drives addr_out) plus one skid register; FSM states EMPTY, ONE, TWO.
REQ-018 EMPTY: input transfer -> ONE; no transfer -> EMPTY.
REQ-019 ONE: input only -> TWO (word to skid); output only -> EMPTY; both -> ONE with new word in main; neither -> ONE.
REQ-020 TWO: output transfer -> ONE with skid moved to main; otherwise TWO; no input accepted in TWO.
REQ-021 in_ready = 1 in EMPTY and ONE, 0 in TWO, registered from next state.
REQ-022 out_valid = 1 in ONE and TWO, 0 in EMPTY.
REQ-023 While out_valid && !out_ready, addr_out (and sel_err) stay stable.
REQ-024 Words leave in acceptance order; no loss or duplication under any in_valid/out_ready pattern.
REQ-025 Sustained throughput: one word per cycle when out_ready held high.

Reset
REQ-026 While reset high: state EMPTY, addr_out = 0, out_valid = 0, sel_err = 0, skid cleared, in_valid ignored.
REQ-027 in_ready = 1 from the first cycle after reset deasserts; reset mid-stream discards main and skid contents.

Configuration
REQ-028 Macro ADDR_MUX_PIPE_SELCHK_EN defined: sel_err port exists, stored alongside each word (main and skid), high exactly while the out-of-range word is on addr_out.
REQ-029 Macro undefined: no sel_err port or storage; out-of-range behaviour still per REQ-016.

Structure
REQ-030 Shared package addr_mux_pkg holds the FSM state enum (EMPTY, ONE, TWO) and the default WIDTH/NUM_IN constants.
REQ-031 One sub-module addr_mux_sel: combinational NUM_IN:1 WIDTH-bit selector with out-of-range detect; addr_mux_pipe instantiates it once.

Verification (NUM_IN=3, WIDTH=5)
REQ-032 Reset: reset high 2 cycles -> out_valid=0, addr_out=0, in_ready=1 the cycle after release.
REQ-033 Single word: ch0=3, ch1=17, ch2=30, sel=1, out_ready=1 -> addr_out=17, out_valid=1 one cycle later, EMPTY after.
REQ-034 Backpressure: out_ready=0, push sel=0 then sel=2 -> in_ready=0 after second, addr_out=3 held; out_ready=1 -> 3 then 30 in order, in_ready=1.
REQ-035 Streaming: 8 back-to-back words, out_ready=1 -> 8 outputs on 8 consecutive cycles, same order.
REQ-036 Out-of-range: sel=3 -> addr_out=0; with ADDR_MUX_PIPE_SELCHK_EN sel_err=1 for that word only.
REQ-037 Reset mid-operation in TWO -> both words discarded, out_valid=0 next cycle, no stale word after release.

Source files
------------

// File: rtl/addr_mux_pkg.sv
// Shared definitions for the address mux pipeline: FSM state encoding and
// default channel geometry.
package addr_mux_pkg;

  localparam int DEF_WIDTH  = 5;
  localparam int DEF_NUM_IN = 2;

  // Encodings kept as plain constants so older code comparing raw bits still works.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  typedef enum logic [1:0] {
    EMPTY = ST_EMPTY,
    ONE   = ST_ONE,
    TWO   = ST_TWO
  } state_t;

  function automatic int sel_width(input int num_in);
    return (num_in > 1) ? $clog2(num_in) : 1;
  endfunction

endpackage

// File: rtl/addr_mux_sel.sv
// Combinational NUM_IN:1 selector over a flattened address bus. A select value
// with no matching channel yields an all-zero word and raises oor.
module addr_mux_sel
  import addr_mux_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int NUM_IN = DEF_NUM_IN,
  localparam int SEL_W = sel_width(NUM_IN)
) (
  input  logic [NUM_IN*WIDTH-1:0] addr_in,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        word,
  output logic                    oor
);

  always_comb begin
    word = '0;
    oor  = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (int'(sel) == k) begin
        word = addr_in[k*WIDTH +: WIDTH];
        oor  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/addr_mux_pipe.sv
// Registered address mux with a valid/ready handshake and a one-entry skid
// buffer. Define ADDR_MUX_PIPE_SELCHK_EN to add the sel_err flag per word.
module addr_mux_pipe
  import addr_mux_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int NUM_IN = DEF_NUM_IN,
  localparam int SEL_W = sel_width(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] addr_in,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        addr_out,
  output logic                    out_valid,
`ifdef ADDR_MUX_PIPE_SELCHK_EN
  output logic                    sel_err,
`endif
  input  logic                    out_ready
);

  logic [WIDTH-1:0] word_p0;
  logic             in_xfer;
  logic             out_xfer;
  logic             load_main;
  logic             load_skid;
  logic             pop_skid;
  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] main_p1;
  logic [WIDTH-1:0] skid_p1;

`ifdef ADDR_MUX_PIPE_SELCHK_EN
  logic oor_p0;
  logic err_main_p1;
  logic err_skid_p1;
`else
  logic oor_unused;
`endif

  // ---- stage p0: channel select on the incoming word ----
  addr_mux_sel #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN)
  ) u_sel (
    .addr_in (addr_in),
    .sel     (sel),
    .word    (word_p0),
`ifdef ADDR_MUX_PIPE_SELCHK_EN
    .oor     (oor_p0)
`else
    .oor     (oor_unused)
`endif
  );

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (in_xfer) state_nxt = ONE;
      ONE: begin
        if (in_xfer && !out_xfer)      state_nxt = TWO;
        else if (!in_xfer && out_xfer) state_nxt = EMPTY;
      end
      TWO:     if (out_xfer) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
  end

  // The main register takes a new word when it is free or being drained in the
  // same cycle; otherwise an accepted word parks in the skid register.
  assign load_main = in_xfer && ((state == EMPTY) || ((state == ONE) && out_xfer));
  assign load_skid = in_xfer && (state == ONE) && !out_xfer;
  assign pop_skid  = (state == TWO) && out_xfer;

  // ---- stage p1: main/skid storage and handshake state ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= EMPTY;
      in_ready <= 1'b1;
      main_p1  <= '0;
      skid_p1  <= '0;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt != TWO);
      if (load_main)     main_p1 <= word_p0;
      else if (pop_skid) main_p1 <= skid_p1;
      if (load_skid)     skid_p1 <= word_p0;
    end
  end

`ifdef ADDR_MUX_PIPE_SELCHK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      err_main_p1 <= 1'b0;
      err_skid_p1 <= 1'b0;
    end else begin
      if (load_main)     err_main_p1 <= oor_p0;
      else if (pop_skid) err_main_p1 <= err_skid_p1;
      if (load_skid)     err_skid_p1 <= oor_p0;
    end
  end

  assign sel_err = err_main_p1;
`endif

  assign addr_out  = main_p1;
  assign out_valid = (state != EMPTY);

endmodule

// File: tb/tb_addr_mux_pipe.sv
// Directed bench for addr_mux_pipe with NUM_IN=3, WIDTH=5: reset, single word,
// backpressure, streaming, out-of-range select and reset while full.
module tb_addr_mux_pipe;

  localparam int WIDTH  = 5;
  localparam int NUM_IN = 3;

  logic                    clk;
  logic                    reset;
  logic [NUM_IN*WIDTH-1:0] addr_in;
  logic [1:0]              sel;
  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        addr_out;
  logic                    out_valid;
  logic                    out_ready;
`ifdef ADDR_MUX_PIPE_SELCHK_EN
  logic                    sel_err;
`endif

  int errors = 0;
  int checks = 0;

  addr_mux_pipe #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .addr_in   (addr_in),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .addr_out  (addr_out),
    .out_valid (out_valid),
`ifdef ADDR_MUX_PIPE_SELCHK_EN
    .sel_err   (sel_err),
`endif
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sel       = 2'd0;
    addr_in   = {5'd30, 5'd17, 5'd3};

    // Reset held for two cycles
    tick();
    tick();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_addr_out", 32'(addr_out), 0);
`ifdef ADDR_MUX_PIPE_SELCHK_EN
    chk("rst_sel_err", 32'(sel_err), 0);
`endif
    reset = 1'b0;
    tick();
    chk("post_rst_in_ready", 32'(in_ready), 1);
    chk("post_rst_out_valid", 32'(out_valid), 0);

    // Single word, sel=1 -> 17
    out_ready = 1'b1;
    sel       = 2'd1;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("single_out_valid", 32'(out_valid), 1);
    chk("single_addr_out", 32'(addr_out), 17);
    tick();
    chk("single_drained", 32'(out_valid), 0);
    chk("single_in_ready", 32'(in_ready), 1);

    // Backpressure: push 3 then 30 with out_ready low
    out_ready = 1'b0;
    sel       = 2'd0;
    in_valid  = 1'b1;
    tick();
    chk("bp_first_in_ready", 32'(in_ready), 1);
    sel = 2'd2;
    tick();
    in_valid = 1'b0;
    chk("bp_full_in_ready", 32'(in_ready), 0);
    chk("bp_full_addr_out", 32'(addr_out), 3);
    tick();
    chk("bp_hold_addr_out", 32'(addr_out), 3);
    chk("bp_hold_out_valid", 32'(out_valid), 1);
    out_ready = 1'b1;
    tick();
    chk("bp_second_addr_out", 32'(addr_out), 30);
    chk("bp_second_out_valid", 32'(out_valid), 1);
    chk("bp_in_ready_back", 32'(in_ready), 1);
    tick();
    chk("bp_drained", 32'(out_valid), 0);

    // Streaming: 8 back-to-back words, channel k of word i = i + 10*k
    for (int i = 0; i < 8; i++) begin
      addr_in  = {5'(i + 20), 5'(i + 10), 5'(i)};
      sel      = 2'(i % 3);
      in_valid = 1'b1;
      tick();
      chk($sformatf("stream_valid_%0d", i), 32'(out_valid), 1);
      chk($sformatf("stream_data_%0d", i), 32'(addr_out), 32'(i + 10 * (i % 3)));
      chk($sformatf("stream_ready_%0d", i), 32'(in_ready), 1);
    end
    in_valid = 1'b0;
    tick();
    chk("stream_drained", 32'(out_valid), 0);

    // Out-of-range select then a normal word
    addr_in  = {5'd30, 5'd17, 5'd3};
    sel      = 2'd3;
    in_valid = 1'b1;
    tick();
    chk("oor_addr_out", 32'(addr_out), 0);
    chk("oor_out_valid", 32'(out_valid), 1);
`ifdef ADDR_MUX_PIPE_SELCHK_EN
    chk("oor_sel_err", 32'(sel_err), 1);
`endif
    sel = 2'd2;
    tick();
    in_valid = 1'b0;
    chk("after_oor_addr_out", 32'(addr_out), 30);
`ifdef ADDR_MUX_PIPE_SELCHK_EN
    chk("after_oor_sel_err", 32'(sel_err), 0);
`endif
    tick();
    chk("oor_drained", 32'(out_valid), 0);

    // Fill both registers, then reset mid-stream
    out_ready = 1'b0;
    sel       = 2'd0;
    in_valid  = 1'b1;
    tick();
    sel = 2'd1;
    tick();
    in_valid = 1'b0;
    chk("midrst_full", 32'(in_ready), 0);
    reset = 1'b1;
    tick();
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_addr_out", 32'(addr_out), 0);
    reset     = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("midrst_in_ready", 32'(in_ready), 1);
    chk("midrst_no_stale", 32'(out_valid), 0);
    sel      = 2'd2;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("midrst_fresh_addr", 32'(addr_out), 30);
    chk("midrst_fresh_valid", 32'(out_valid), 1);
    tick();
    chk("midrst_final_empty", 32'(out_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
